// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN to build the first-word-fall-through read variant.
module sync_fifo_flags #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned AF_LEVEL  = (1 << ADDR_SIZE) - 2,
  parameter int unsigned AE_LEVEL  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_en,
  input  logic [DATA_SIZE-1:0] w_data,
  input  logic                 r_en,
  input  logic                 clr_err,
  output logic [DATA_SIZE-1:0] r_data,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned Depth = 1 << ADDR_SIZE;
  localparam int unsigned PtrW  = ADDR_SIZE + 1;

  typedef logic [ADDR_SIZE:0] ptr_t;
  localparam ptr_t PtrOne = ptr_t'(1);

  logic [DATA_SIZE-1:0] mem_q [Depth];
  ptr_t                 wptr_q, wptr_d;
  ptr_t                 rptr_q, rptr_d;
  logic [DATA_SIZE-1:0] r_data_q, r_data_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 w_acc, r_acc;

  // Modulo subtraction of the extra-MSB pointers yields 0..Depth directly.
  assign count        = wptr_q - rptr_q;
  assign full         = (count == PtrW'(Depth));
  assign almost_full  = (count >= PtrW'(AF_LEVEL));
  assign almost_empty = (count <= PtrW'(AE_LEVEL));
  assign w_acc        = w_en & ~full;

`ifdef FIFO_FWFT_EN
  // fptr tracks the next memory word to pre-fetch; rptr advances on acknowledge,
  // so count still includes the word sitting in the output register.
  ptr_t fptr_q, fptr_d;
  logic valid_q, valid_d;
  logic fetch;

  assign empty = ~valid_q;
  assign r_acc = r_en & valid_q;

  always_comb begin
    fptr_d   = fptr_q;
    valid_d  = valid_q;
    r_data_d = r_data_q;
    fetch    = (wptr_q != fptr_q) && (!valid_q || r_acc);
    if (fetch) begin
      r_data_d = mem_q[fptr_q[ADDR_SIZE-1:0]];
      fptr_d   = fptr_q + PtrOne;
      valid_d  = 1'b1;
    end else if (r_acc) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fptr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      fptr_q  <= fptr_d;
      valid_q <= valid_d;
    end
  end
`else
  assign empty = (count == '0);
  assign r_acc = r_en & ~empty;

  always_comb begin
    r_data_d = r_data_q;
    if (r_acc) begin
      r_data_d = mem_q[rptr_q[ADDR_SIZE-1:0]];
    end
  end
`endif

  always_comb begin
    wptr_d      = w_acc ? wptr_q + PtrOne : wptr_q;
    rptr_d      = r_acc ? rptr_q + PtrOne : rptr_q;
    // A new error event outranks a clear in the same cycle.
    overflow_d  = (w_en & full) | (overflow_q & ~clr_err);
    underflow_d = (r_en & empty) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      r_data_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      r_data_q    <= r_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      mem_q[wptr_q[ADDR_SIZE-1:0]] <= w_data;
    end
  end

  assign r_data    = r_data_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
